id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 49 ++++
 rtl/id_ex_stage_hazard_detect.sv | 38 +++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared CPU definitions used by the ID/EX pipeline register and its hazard
// logic.
//   - REG_ZERO      : architectural register 0 (hard-wired zero, never a
//                     real producer, so it never creates a dependency)
//   - CTRL_*        : bit positions of the decoded control fields inside the
//                     16-bit ctrl word carried from ID to EX
//   - id_ex_t       : the full ID->EX payload, in the order the pipeline
//                     register stores it
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

   localparam int          CTRL_W   = 16;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   // Decoded control field positions within ctrl[15:0]; the ID/EX register
   // carries the word opaquely, EX-stage consumers slice it with these.
   localparam int CTRL_ALU_OP_LSB = 0;
   localparam int CTRL_ALU_OP_MSB = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_MEM_WRITE  = 5;
   localparam int CTRL_BRANCH     = 6;
   localparam int CTRL_JUMP       = 7;
   localparam int CTRL_WB_SEL_LSB = 8;
   localparam int CTRL_WB_SEL_MSB = 9;
   localparam int CTRL_LINK       = 10;
   localparam int CTRL_SIGNED     = 11;
   localparam int CTRL_SIZE_LSB   = 12;
   localparam int CTRL_SIZE_MSB   = 13;
   localparam int CTRL_CSR        = 14;
   localparam int CTRL_ILLEGAL    = 15;

   typedef struct packed {
      logic [31:0]       ra;
      logic [31:0]       rb;
      logic [31:0]       imm;
      logic [31:0]       pc;
      logic [4:0]        r_a;
      logic [4:0]        r_b;
      logic [4:0]        r_w;
      logic              rw_en;
      logic              rb_valid;
      logic              mem_read;
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector for the ID/EX boundary.
//   i_valid_id, i_r_a_id, i_r_b_id, i_rb_valid_id : instruction in ID
//   i_valid_ex, i_mem_read_ex, i_rw_en_ex, i_r_w_ex : instruction in EX
//   i_flush       : EX redirect, the ID instruction is wrong-path
//   o_load_use    : ID needs a value a load in EX has not produced yet
//   o_stall_if    : hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       i_valid_id,
   input  logic [4:0] i_r_a_id,
   input  logic [4:0] i_r_b_id,
   input  logic       i_rb_valid_id,
   input  logic       i_valid_ex,
   input  logic       i_mem_read_ex,
   input  logic       i_rw_en_ex,
   input  logic [4:0] i_r_w_ex,
   input  logic       i_flush,
   output logic       o_load_use,
   output logic       o_stall_if
);

   logic w_ex_is_load;
   logic w_src_match;

   // A load writing r0 produces nothing anyone can depend on.
   assign w_ex_is_load = i_valid_ex & i_mem_read_ex & i_rw_en_ex & (i_r_w_ex != REG_ZERO);
   // Source B only matters when the instruction actually reads it.
   assign w_src_match  = (i_r_w_ex == i_r_a_id) | (i_rb_valid_id & (i_r_w_ex == i_r_b_id));

   assign o_load_use = i_valid_id & w_ex_is_load & w_src_match;
   // A wrong-path instruction is squashed anyway, so stalling for it is wasted.
   assign o_stall_if = o_load_use & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// saturating bubble statistics.
//   clk, rst                 : clock, asynchronous active-high reset
//   RAID..ctrlID             : decoded instruction in ID
//   branchTakenEX            : EX redirect, squashes the ID instruction
//   RAEX..ctrlEX             : registered EX copy (all zero for a bubble)
//   stallIF                  : combinational hold for PC and IF/ID
//   loadUseCnt, flushCnt     : saturating bubble counters
// Each cycle is either PASS (capture ID) or BUBBLE (load zeros). A load-use
// bubble clears memReadEX, so the stall it causes lasts exactly one cycle.
// ---------------------------------------------------------------------------
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       RAID,
   input  logic [31:0]       RBID,
   input  logic [31:0]       immID,
   input  logic [31:0]       pcID,
   input  logic [4:0]        rAID,
   input  logic [4:0]        rBID,
   input  logic [4:0]        rWID,
   input  logic              rW_enID,
   input  logic              rBValidID,
   input  logic              memReadID,
   input  logic              validID,
   input  logic [CTRL_W-1:0] ctrlID,
   input  logic              branchTakenEX,
   output logic [31:0]       RAEX,
   output logic [31:0]       RBEX,
   output logic [31:0]       immEX,
   output logic [31:0]       pcEX,
   output logic [4:0]        rAEX,
   output logic [4:0]        rBEX,
   output logic [4:0]        rWEX,
   output logic              rW_enEX,
   output logic              rBValidEX,
   output logic              memReadEX,
   output logic              validEX,
   output logic [CTRL_W-1:0] ctrlEX,
   output logic              stallIF,
   output logic [CNT_W-1:0]  loadUseCnt,
   output logic [CNT_W-1:0]  flushCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   id_ex_t           w_id;
   id_ex_t           r_ex;
   logic             w_load_use;
   logic             w_flush;
   logic [CNT_W-1:0] r_load_use_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_id    = {RAID, RBID, immID, pcID, rAID, rBID, rWID,
                     rW_enID, rBValidID, memReadID, validID, ctrlID};
   assign w_flush = branchTakenEX;

   hazard_detect u_hazard_detect (
      .i_valid_id    (validID),
      .i_r_a_id      (rAID),
      .i_r_b_id      (rBID),
      .i_rb_valid_id (rBValidID),
      .i_valid_ex    (r_ex.valid),
      .i_mem_read_ex (r_ex.mem_read),
      .i_rw_en_ex    (r_ex.rw_en),
      .i_r_w_ex      (r_ex.r_w),
      .i_flush       (w_flush),
      .o_load_use    (w_load_use),
      .o_stall_if    (stallIF)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex           <= '0;
         r_load_use_cnt <= '0;
         r_flush_cnt    <= '0;
      end else if (w_flush) begin
         // Flush wins over load-use: the bubble is charged to the flush only.
         r_ex <= '0;
         if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else if (w_load_use) begin
         r_ex <= '0;
         if (r_load_use_cnt != CNT_MAX) r_load_use_cnt <= r_load_use_cnt + CNT_ONE;
      end else begin
         r_ex <= w_id;
      end
   end

   assign RAEX       = r_ex.ra;
   assign RBEX       = r_ex.rb;
   assign immEX      = r_ex.imm;
   assign pcEX       = r_ex.pc;
   assign rAEX       = r_ex.r_a;
   assign rBEX       = r_ex.r_b;
   assign rWEX       = r_ex.r_w;
   assign rW_enEX    = r_ex.rw_en;
   assign rBValidEX  = r_ex.rb_valid;
   assign memReadEX  = r_ex.mem_read;
   assign validEX    = r_ex.valid;
   assign ctrlEX     = r_ex.ctrl;
   assign loadUseCnt = r_load_use_cnt;
   assign flushCnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int CNT_W = 4;
  localparam int EX_W  = $bits(id_ex_t);

  typedef struct {
    id_ex_t d;
    logic   br;
    logic   exp_stall;
    logic   exp_bubble;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] RAID, RBID, immID, pcID;
  logic [4:0]  rAID, rBID, rWID;
  logic        rW_enID, rBValidID, memReadID, validID, branchTakenEX;
  logic [15:0] ctrlID;
  logic [31:0] RAEX, RBEX, immEX, pcEX;
  logic [4:0]  rAEX, rBEX, rWEX;
  logic        rW_enEX, rBValidEX, memReadEX, validEX, stallIF;
  logic [15:0] ctrlEX;
  logic [CNT_W-1:0] loadUseCnt, flushCnt;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RAID(RAID), .RBID(RBID), .immID(immID), .pcID(pcID),
    .rAID(rAID), .rBID(rBID), .rWID(rWID),
    .rW_enID(rW_enID), .rBValidID(rBValidID), .memReadID(memReadID), .validID(validID),
    .ctrlID(ctrlID), .branchTakenEX(branchTakenEX),
    .RAEX(RAEX), .RBEX(RBEX), .immEX(immEX), .pcEX(pcEX),
    .rAEX(rAEX), .rBEX(rBEX), .rWEX(rWEX),
    .rW_enEX(rW_enEX), .rBValidEX(rBValidEX), .memReadEX(memReadEX), .validEX(validEX),
    .ctrlEX(ctrlEX), .stallIF(stallIF),
    .loadUseCnt(loadUseCnt), .flushCnt(flushCnt)
  );

  // scoreboard
  logic [EX_W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int m_lu  = 0;
  int m_fl  = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic id_ex_t dut_ex();
    return {RAEX, RBEX, immEX, pcEX, rAEX, rBEX, rWEX,
            rW_enEX, rBValidEX, memReadEX, validEX, ctrlEX};
  endfunction

  function automatic vec_t mk(input logic [31:0] ra, input logic [31:0] rb,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                              input logic wen, input logic bv, input logic mr, input logic val,
                              input logic [15:0] ctrl, input logic br,
                              input logic st, input logic bu);
    vec_t v;
    v.d = {ra, rb, imm, pc, a, b, w, wen, bv, mr, val, ctrl};
    v.br = br;
    v.exp_stall = st;
    v.exp_bubble = bu;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    RAID = v.d.ra; RBID = v.d.rb; immID = v.d.imm; pcID = v.d.pc;
    rAID = v.d.r_a; rBID = v.d.r_b; rWID = v.d.r_w;
    rW_enID = v.d.rw_en; rBValidID = v.d.rb_valid; memReadID = v.d.mem_read;
    validID = v.d.valid; ctrlID = v.d.ctrl; branchTakenEX = v.br;
  endtask

  task automatic pop_check(input string name);
    logic [EX_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_ex"}, dut_ex(), e);
    end
    chk({name, "_loadUseCnt"}, loadUseCnt, m_lu[CNT_W-1:0]);
    chk({name, "_flushCnt"}, flushCnt, m_fl[CNT_W-1:0]);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step(input string name, input vec_t v);
    drive(v);
    #1;
    chk({name, "_stallIF"}, stallIF, v.exp_stall);
    exp_q.push_back(v.exp_bubble ? '0 : v.d);
    if (v.br) begin
      if (m_fl < 15) m_fl++;
    end else if (v.exp_stall) begin
      if (m_lu < 15) m_lu++;
    end
    @(negedge clk);
    pop_check(name);
  endtask

  vec_t tbl[16];
  vec_t pre, haz, fv;

  initial begin
    tbl[0]  = mk(32'h11, 32'h22, 32'h33, 32'h100, 3, 4, 6, 1, 1, 0, 1, 16'h00a5, 0, 0, 0);
    tbl[1]  = mk(32'h1000, 32'h2000, 32'h4, 32'h104, 1, 2, 5, 1, 1, 1, 1, 16'h0102, 0, 0, 0);
    tbl[2]  = mk(32'h5a5a, 32'h0, 32'h8, 32'h108, 5, 6, 7, 1, 1, 0, 1, 16'h0203, 0, 1, 1);
    tbl[3]  = mk(32'h5a5a, 32'h0, 32'h8, 32'h108, 5, 6, 7, 1, 1, 0, 1, 16'h0203, 0, 0, 0);
    tbl[4]  = mk(32'h3, 32'h4, 32'hc, 32'h10c, 8, 9, 5, 1, 1, 1, 1, 16'h0304, 0, 0, 0);
    tbl[5]  = mk(32'h6, 32'h7, 32'h10, 32'h110, 1, 5, 0, 1, 0, 1, 1, 16'h0405, 0, 0, 0);
    tbl[6]  = mk(32'h8, 32'h9, 32'h14, 32'h114, 0, 3, 9, 1, 1, 1, 1, 16'h0506, 0, 0, 0);
    tbl[7]  = mk(32'ha, 32'hb, 32'h18, 32'h118, 2, 9, 11, 1, 1, 0, 1, 16'h0607, 0, 1, 1);
    tbl[8]  = mk(32'hc, 32'hd, 32'h1c, 32'h11c, 3, 4, 10, 1, 1, 1, 1, 16'h0708, 0, 0, 0);
    tbl[9]  = mk(32'hdead, 32'hbeef, 32'h20, 32'h120, 10, 10, 12, 1, 1, 0, 0, 16'h0809, 0, 0, 0);
    tbl[10] = mk(32'he, 32'hf, 32'h24, 32'h124, 4, 5, 12, 1, 1, 1, 1, 16'h090a, 0, 0, 0);
    tbl[11] = mk(32'h10, 32'h11, 32'h28, 32'h128, 12, 1, 14, 1, 1, 0, 1, 16'h0a0b, 1, 0, 1);
    tbl[12] = mk(32'h10, 32'h11, 32'h28, 32'h128, 12, 1, 13, 0, 1, 1, 1, 16'h0b0c, 0, 0, 0);
    tbl[13] = mk(32'h12, 32'h13, 32'h2c, 32'h12c, 13, 13, 2, 1, 1, 0, 1, 16'h0c0d, 0, 0, 0);
    tbl[14] = mk(32'h14, 32'h15, 32'h30, 32'h130, 1, 2, 3, 1, 1, 0, 1, 16'h0d0e, 1, 0, 1);
    tbl[15] = mk('1, '1, '1, '1, 31, 31, 31, 1, 1, 0, 1, 16'hffff, 0, 0, 0);

    // reset with a valid-looking ID instruction present
    drive(tbl[0]);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_ex", dut_ex(), '0);
    chk("reset_stallIF", stallIF, 0);
    chk("reset_loadUseCnt", loadUseCnt, 0);
    chk("reset_flushCnt", flushCnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

    // reset between edges while a stall is pending
    pre = mk(32'h77, 32'h88, 32'h40, 32'h200, 1, 2, 5, 1, 1, 1, 1, 16'h1111, 0, 0, 0);
    haz = mk(32'h99, 32'haa, 32'h44, 32'h204, 5, 0, 6, 1, 0, 0, 1, 16'h2222, 0, 1, 1);
    step("pre_load", pre);
    drive(haz);
    #1;
    chk("midrst_stall_before", stallIF, 1);
    #1 rst = 1'b1;
    #1;
    m_lu = 0;
    m_fl = 0;
    chk("midrst_ex_async", dut_ex(), '0);
    chk("midrst_stallIF", stallIF, 0);
    chk("midrst_loadUseCnt", loadUseCnt, 0);
    chk("midrst_flushCnt", flushCnt, 0);
    #1 rst = 1'b0;
    exp_q.push_back(haz.d);
    @(negedge clk);
    pop_check("post_rst_capture");

    // flush counter saturation
    for (int i = 0; i < 20; i++) begin
      fv = mk($urandom, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 16'($urandom), 1, 0, 1);
      step($sformatf("flush%0d", i), fv);
    end
    chk("flush_saturated", flushCnt, 4'd15);
    chk("flush_sat_loadUseCnt", loadUseCnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
